// File: rtl/font_row_serializer.sv
// Glyph-row serializer: looks up one row of a stored bitmap font and streams it
// out one pixel per handshake, leftmost first, with horizontal scaling and inversion.
module font_row_serializer #(
  parameter int          GLYPH_W    = 8,
  parameter int          GLYPH_H    = 16,
  parameter int          NUM_GLYPHS = 10,
  parameter logic [7:0]  BASE_CODE  = 8'h30,
  // Glyph 0 row 0 sits in the most significant GLYPH_W bits; bit GLYPH_W-1 of a row is leftmost.
  parameter logic [NUM_GLYPHS*GLYPH_H*GLYPH_W-1:0] GLYPH_ROM = {
    128'h00007CC6C6CEDEF6E6C6C67C00000000,  // '0'
    128'h00001838781818181818187E00000000,  // '1'
    128'h00007CC6060C183060C0C6FE00000000,  // '2'
    128'h00007CC606063C060606C67C00000000,  // '3'
    128'h00000C1C3C6CCCFE0C0C0C1E00000000,  // '4'
    128'h0000FEC0C0C0FC060606C67C00000000,  // '5'
    128'h00003860C0C0FCC6C6C6C67C00000000,  // '6'
    128'h0000FEC606060C183030303000000000,  // '7'
    128'h00007CC6C6C67CC6C6C6C67C00000000,  // '8'
    128'h00007CC6C6C67E0606060C7800000000   // '9'
  }
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [7:0]                 i_req_code,
  input  logic [$clog2(GLYPH_H)-1:0] i_req_row,
  input  logic [1:0]                 i_req_scale,
  input  logic                       i_req_invert,
  output logic                       o_pix_valid,
  input  logic                       i_pix_ready,
  output logic                       o_pix_data,
  output logic                       o_pix_last,
  output logic                       o_bad_code
);
  localparam int ROW_W   = $clog2(GLYPH_H);
  localparam int GI_W    = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1;
  localparam int CNT_W   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int ENTRIES = NUM_GLYPHS * GLYPH_H;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT} state_t;

  state_t             r_state;
  logic [GI_W-1:0]    r_glyph;
  logic [ROW_W-1:0]   r_row;
  logic [1:0]         r_scale;
  logic               r_invert;
  logic               r_ok;
  logic [GLYPH_W-1:0] r_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [1:0]         r_rep;
  logic               r_req_ready, r_pix_valid, r_pix_data, r_pix_last, r_bad_code;

  logic               w_accept, w_code_ok, w_row_ok, w_hs, w_adv_bit, w_final, w_next_last;
  logic [31:0]        w_entry;
  logic [GLYPH_W-1:0] w_rom_row, w_fetch_row, w_shl;

  assign w_accept  = i_req_valid && r_req_ready;
  assign w_code_ok = (i_req_code >= BASE_CODE) &&
                     (32'(i_req_code) < 32'(BASE_CODE) + 32'(NUM_GLYPHS));
  assign w_row_ok  = 32'(i_req_row) < 32'(GLYPH_H);

  // Out-of-range requests index entry 0 and are then masked to an all-zero row.
  assign w_entry     = r_ok ? (32'(r_glyph) * 32'(GLYPH_H) + 32'(r_row)) : 32'd0;
  assign w_rom_row   = GLYPH_ROM[(32'(ENTRIES) - 32'd1 - w_entry) * 32'(GLYPH_W) +: GLYPH_W];
  assign w_fetch_row = r_ok ? w_rom_row : '0;

  assign w_hs        = r_pix_valid && i_pix_ready;
  assign w_adv_bit   = (r_rep == r_scale);
  assign w_final     = (32'(r_bit_cnt) == 32'(GLYPH_W - 1)) && w_adv_bit;
  assign w_shl       = r_shift << 1;
  // Look-ahead so pix_last is registered alongside the pixel it marks.
  assign w_next_last = w_adv_bit
    ? ((r_scale == 2'd0) && (32'(r_bit_cnt) == 32'(GLYPH_W - 2)))
    : ((32'(r_bit_cnt) == 32'(GLYPH_W - 1)) && ((r_rep + 2'd1) == r_scale));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_glyph     <= '0;
      r_row       <= '0;
      r_scale     <= '0;
      r_invert    <= 1'b0;
      r_ok        <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_rep       <= '0;
      r_req_ready <= 1'b1;
      r_pix_valid <= 1'b0;
      r_pix_data  <= 1'b0;
      r_pix_last  <= 1'b0;
      r_bad_code  <= 1'b0;
    end else begin
      r_bad_code <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_state     <= S_FETCH;
          r_req_ready <= 1'b0;
          r_glyph     <= GI_W'(32'(i_req_code) - 32'(BASE_CODE));
          r_row       <= i_req_row;
          r_scale     <= i_req_scale;
          r_invert    <= i_req_invert;
          r_ok        <= w_code_ok && w_row_ok;
          r_bad_code  <= !w_code_ok;
        end
        S_FETCH: begin
          r_state     <= S_SHIFT;
          r_shift     <= w_fetch_row;
          r_bit_cnt   <= '0;
          r_rep       <= '0;
          r_pix_valid <= 1'b1;
          r_pix_data  <= w_fetch_row[GLYPH_W-1] ^ r_invert;
          r_pix_last  <= (GLYPH_W == 1) && (r_scale == 2'd0);
        end
        S_SHIFT: if (w_hs) begin
          if (w_final) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_pix_valid <= 1'b0;
            r_pix_data  <= 1'b0;
            r_pix_last  <= 1'b0;
          end else begin
            r_pix_last <= w_next_last;
            if (w_adv_bit) begin
              r_shift    <= w_shl;
              r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
              r_rep      <= '0;
              r_pix_data <= w_shl[GLYPH_W-1] ^ r_invert;
            end else begin
              r_rep <= r_rep + 2'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_pix_valid = r_pix_valid;
  assign o_pix_data  = r_pix_data;
  assign o_pix_last  = r_pix_last;
  assign o_bad_code  = r_bad_code;
endmodule

// File: tb/tb_font_row_serializer.sv
// Directed scoreboard bench for font_row_serializer: expected pixels are expanded
// from reference row bytes and compared as the DUT hands them over.
module tb_font_row_serializer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [7:0] req_code;
  logic [3:0] req_row;
  logic [1:0] req_scale;
  logic       req_invert;
  logic       pix_valid, pix_ready, pix_data, pix_last, bad_code;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic q[$];

  font_row_serializer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_code(req_code), .i_req_row(req_row),
    .i_req_scale(req_scale), .i_req_invert(req_invert),
    .o_pix_valid(pix_valid), .i_pix_ready(pix_ready),
    .o_pix_data(pix_data), .o_pix_last(pix_last), .o_bad_code(bad_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One request: model the pixel stream, issue it, then drain with optional stalls.
  task automatic run_row(input logic [7:0] code, input logic [3:0] row, input logic [1:0] scale,
                         input logic inv, input logic exp_bad, input logic [7:0] bits,
                         input bit stall, input int abort_after);
    int   cyc, pops;
    logic hold, hold_d, hold_l, exp_d;
    for (int b = 7; b >= 0; b--)
      for (int r = 0; r <= int'(scale); r++) q.push_back(bits[b] ^ inv);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_code = code; req_row = row; req_scale = scale; req_invert = inv;
    @(negedge clk);
    // Garbage on the request bus while busy must be ignored.
    req_code = 8'($urandom); req_row = 4'($urandom); req_scale = 2'($urandom);
    req_invert = 1'($urandom);
    chk("bad_code_n1", bad_code, exp_bad);
    chk("pix_valid_n1", pix_valid, 1'b0);
    chk("req_ready_fetch", req_ready, 1'b0);
    @(negedge clk);
    chk("pix_valid_n2", pix_valid, 1'b1);
    chk("bad_code_n2", bad_code, 1'b0);
    cyc = 0; pops = 0; hold = 1'b0; hold_d = 1'b0; hold_l = 1'b0;
    while (q.size() > 0) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (cyc > 300) begin
        chk("row_done_in_budget", q.size() == 0, 1'b1);
        q.delete();
        break;
      end
      chk("pix_valid_shift", pix_valid, 1'b1);
      if (hold) begin
        chk("stall_data_stable", pix_data, hold_d);
        chk("stall_last_stable", pix_last, hold_l);
      end
      pix_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_valid && pix_ready) begin
        exp_d = q.pop_front();
        chk("pix_data", pix_data, exp_d);
        chk("pix_last", pix_last, q.size() == 0);
        pops++;
        hold = 1'b0;
        if (q.size() == 0) req_valid = 1'b0;
        if (abort_after != 0 && pops == abort_after) break;
      end else begin
        hold = 1'b1; hold_d = pix_data; hold_l = pix_last;
      end
    end
    if (abort_after == 0) begin
      @(negedge clk);
      chk("req_ready_after_last", req_ready, 1'b1);
      chk("pix_valid_after_last", pix_valid, 1'b0);
      chk("pix_last_after_last", pix_last, 1'b0);
    end
    pix_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_code = '0; req_row = '0;
    req_scale = '0; req_invert = 1'b0; pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_pix_data", pix_data, 1'b0);
    chk("rst_pix_last", pix_last, 1'b0);
    chk("rst_bad_code", bad_code, 1'b0);
    rst_n = 1'b1;

    run_row(8'h31, 4'd2, 2'd0, 1'b0, 1'b0, 8'h18, 1'b0, 0);
    run_row(8'h30, 4'd2, 2'd1, 1'b0, 1'b0, 8'h7C, 1'b0, 0);
    run_row(8'h37, 4'd2, 2'd0, 1'b1, 1'b0, 8'hFE, 1'b0, 0);
    run_row(8'h41, 4'd2, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 0);
    run_row(8'h41, 4'd5, 2'd0, 1'b1, 1'b1, 8'h00, 1'b0, 0);
    run_row(8'h2F, 4'd3, 2'd0, 1'b0, 1'b1, 8'h00, 1'b0, 0);
    run_row(8'h3A, 4'd3, 2'd2, 1'b0, 1'b1, 8'h00, 1'b0, 0);
    run_row(8'h38, 4'd6, 2'd0, 1'b0, 1'b0, 8'h7C, 1'b1, 0);
    run_row(8'h34, 4'd7, 2'd2, 1'b1, 1'b0, 8'hFE, 1'b1, 0);

    // Abort a 4x row after its 3rd pixel.
    run_row(8'h30, 4'd2, 2'd3, 1'b0, 1'b0, 8'h7C, 1'b0, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req_ready", req_ready, 1'b1);
    chk("abort_pix_valid", pix_valid, 1'b0);
    chk("abort_pix_data", pix_data, 1'b0);
    chk("abort_pix_last", pix_last, 1'b0);
    chk("abort_bad_code", bad_code, 1'b0);
    q.delete();
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_row(8'h34, 4'd7, 2'd0, 1'b0, 1'b0, 8'hFE, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/font_row_serializer.md
FONT_ROW_SERIALIZER -- requirements
Module: font_row_serializer

Interface
REQ-001 The block SHALL have parameter GLYPH_W, default 8, meaning pixels per glyph row.
REQ-002 The block SHALL have parameter GLYPH_H, default 16, meaning rows per glyph.
REQ-003 The block SHALL have parameter NUM_GLYPHS, default 10, meaning glyphs stored.
REQ-004 The block SHALL have parameter BASE_CODE, default 8'h30, meaning character code of glyph 0.
REQ-005 Clk  input  1  sole clock, all state on rising edge.
REQ-006 Reset_n  input  1  reset, asynchronous and active-low.
REQ-007 req_valid  input  1  request offered.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_code  input  8  character code.
REQ-010 req_row  input  $clog2(GLYPH_H)  glyph row index.
REQ-011 req_scale  input  2  horizontal scale minus one (0 means 1x, 3 means 4x).
REQ-012 req_invert  input  1  invert output pixels.
REQ-013 pix_valid  output  1  pix_data valid.
REQ-014 pix_ready  input  1  downstream accepts pixel.
REQ-015 pix_data  output  1  current pixel, 1 = foreground.
REQ-016 pix_last  output  1  marks final pixel of the row.
REQ-017 bad_code  output  1  one-cycle pulse, out-of-range code accepted.

Function
REQ-018 The block SHALL hold an internal glyph table of NUM_GLYPHS x GLYPH_H rows of GLYPH_W bits; defaults hold the team's 8x16 digit bitmaps for codes 0x30-0x39, row 0 first, bit GLYPH_W-1 leftmost.
REQ-019 A request SHALL be accepted only on a cycle with req_valid and req_ready both high; all req_* fields are captured on that edge.
REQ-020 The FSM SHALL have states IDLE, FETCH, SHIFT; req_ready SHALL be high only in IDLE.
REQ-021 IDLE -> FETCH on acceptance; FETCH -> SHIFT unconditionally after one cycle (registered table read); SHIFT -> IDLE on the handshake of the pixel with pix_last high.
REQ-022 First pix_valid SHALL assert two cycles after the acceptance edge (cycle N accept, FETCH N+1, pix_valid N+2).
REQ-023 Pixels SHALL be emitted leftmost first; each bit SHALL repeat req_scale+1 times, giving GLYPH_W*(req_scale+1) pixels per row.
REQ-024 pix_data SHALL equal table bit XOR captured invert.
REQ-025 pix_valid SHALL stay high throughout SHIFT; pix_data and pix_last SHALL hold steady while pix_valid is high and pix_ready is low.
REQ-026 The pixel counter SHALL advance only on pix_valid and pix_ready both high; pix_last SHALL be high exactly on the final pixel.
REQ-027 A code outside BASE_CODE..BASE_CODE+NUM_GLYPHS-1 SHALL be treated as an all-zero row, and bad_code SHALL pulse high for the cycle after acceptance (the FETCH cycle).
REQ-028 req_row >= GLYPH_H (non-power-of-two heights) SHALL yield an all-zero row without a bad_code pulse.
REQ-029 req_ready SHALL re-assert in the cycle after the last-pixel handshake; back-to-back requests SHALL therefore incur a one-cycle FETCH bubble and no lost pixels.
REQ-030 Input changes while not in IDLE SHALL have no effect.

Reset
REQ-031 On Reset_n low the block SHALL enter IDLE immediately: req_ready=1, pix_valid=0, pix_data=0, pix_last=0, bad_code=0, counters and captured fields cleared.
REQ-032 Reset asserted mid-row SHALL abort the row; after release, the next accepted request SHALL start a fresh row with no residual pixels.

Verification
REQ-033 Code 0x31, row 2, scale 0, invert 0, pix_ready=1 -> pix_valid from N+2, pixels 0,0,0,1,1,0,0,0, pix_last on the 8th, req_ready high at the following cycle.
REQ-034 Code 0x30, row 2, scale 1 -> 16 pixels 0,0,1,1,1,1,1,1,1,1,1,1,0,0,0,0, pix_last on the 16th.
REQ-035 Code 0x37, row 2, invert 1 -> pixels 0,0,0,0,0,0,0,1.
REQ-036 Code 0x41 -> bad_code high exactly at N+1, then 8 zero pixels; with invert 1, 8 one pixels.
REQ-037 Code 0x38, row 6, with pix_ready toggled pseudo-randomly -> stable data while stalled, sequence 0,1,1,1,1,1,0,0, exactly one pix_last.
REQ-038 Reset_n pulsed low after the 3rd pixel of a scale-3 row -> outputs zero asynchronously, req_ready=1, and the next request (code 0x34, row 7) yields 1,1,1,1,1,1,1,0.
